// File: rtl/pc_lut_pkg.sv
`default_nettype none
// ============================================================================
// pc_lut_pkg : shared types and default widths for the PC LUT blocks
// Revision   : 1.0
// ============================================================================
package pc_lut_pkg;

  localparam int DEF_IDX_W = 5;
  localparam int DEF_VAL_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } lut_state_e;

endpackage : pc_lut_pkg
`default_nettype wire

// File: rtl/pc_lut_table.sv
`default_nettype none
// ============================================================================
// pc_lut_table : value array with per-entry valid bits, one write port and
//                one combinational indexed read port (reads see old contents)
// Revision     : 1.0
// ============================================================================
module pc_lut_table
  import pc_lut_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int VAL_W = DEF_VAL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [VAL_W-1:0] i_wr_val,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [VAL_W-1:0] o_rd_val,
  output logic             o_rd_vld
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [VAL_W-1:0] vals_q [DEPTH];
  logic [VAL_W-1:0] vals_d [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;

  always_comb begin
    vals_d = vals_q;
    vld_d  = vld_q;
    if (i_wr_en) begin
      vals_d[i_wr_idx] = i_wr_val;
      vld_d[i_wr_idx]  = 1'b1;
    end
  end

  // Stored values are not cleared by reset, but they are frozen while it is
  // asserted so a write during reset leaves no trace.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q  <= vld_d;
      vals_q <= vals_d;
    end
  end

  assign o_rd_val = vals_q[i_rd_idx];
  assign o_rd_vld = vld_q[i_rd_idx];

endmodule : pc_lut_table
`default_nettype wire

// File: rtl/pc_lut_encoder.sv
`default_nettype none
// ============================================================================
// pc_lut_encoder : reverse lookup -- sequentially scans the table for the
//                  lowest valid index holding a requested value
// Revision       : 1.0
// ============================================================================
module pc_lut_encoder
  import pc_lut_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int VAL_W = DEF_VAL_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [VAL_W-1:0] wr_val,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [VAL_W-1:0] req_val,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IDX_W-1:0] rsp_idx,
  output logic             rsp_hit
);

  localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

  lut_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [VAL_W-1:0] key_q, key_d;
  logic [IDX_W-1:0] rsp_idx_q, rsp_idx_d;
  logic             rsp_hit_q, rsp_hit_d;

  logic [VAL_W-1:0] rd_val;
  logic             rd_vld;
  logic             match;

  pc_lut_table #(
    .IDX_W (IDX_W),
    .VAL_W (VAL_W)
  ) u_table (
    .clk      (Clk),
    .rst      (Reset),
    .i_wr_en  (wr_en),
    .i_wr_idx (wr_idx),
    .i_wr_val (wr_val),
    .i_rd_idx (ptr_q),
    .o_rd_val (rd_val),
    .o_rd_vld (rd_vld)
  );

  assign match = rd_vld && (rd_val == key_q);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    key_d     = key_q;
    rsp_idx_d = rsp_idx_q;
    rsp_hit_d = rsp_hit_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          key_d   = req_val;
          ptr_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // One entry per cycle; the first match stops the scan, so the
        // lowest index wins and passed entries are never revisited.
        if (match) begin
          rsp_idx_d = ptr_q;
          rsp_hit_d = 1'b1;
          state_d   = RESP;
        end else if (ptr_q == LAST_IDX) begin
          rsp_idx_d = '0;
          rsp_hit_d = 1'b0;
          state_d   = RESP;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      key_q     <= '0;
      rsp_idx_q <= '0;
      rsp_hit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      key_q     <= key_d;
      rsp_idx_q <= rsp_idx_d;
      rsp_hit_q <= rsp_hit_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_idx   = rsp_idx_q;
  assign rsp_hit   = rsp_hit_q;

endmodule : pc_lut_encoder
`default_nettype wire

// File: doc/pc_lut_encoder.md
PC_LUT_ENCODER -- requirements
Module: pc_lut_encoder

Interface
REQ-001 SHALL have parameter IDX_W, default 5, meaning the table index width.
REQ-002 SHALL have parameter VAL_W, default 8, meaning the target-value width; DEPTH = 2**IDX_W entries.
REQ-003 SHALL have port Clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1  writes a table entry this cycle.
REQ-006 SHALL have port wr_idx  input  IDX_W  the entry written.
REQ-007 SHALL have port wr_val  input  VAL_W  the value stored; the entry is also marked valid.
REQ-008 SHALL have port req_valid  input  1  a reverse-lookup request is presented.
REQ-009 SHALL have port req_ready  output  1  the block accepts a request.
REQ-010 SHALL have port req_val  input  VAL_W  the target value to search for.
REQ-011 SHALL have port rsp_valid  output  1  a lookup result is presented.
REQ-012 SHALL have port rsp_ready  input  1  the consumer accepts the result.
REQ-013 SHALL have port rsp_idx  output  IDX_W  the lowest matching index; 0 on a miss.
REQ-014 SHALL have port rsp_hit  output  1  at least one valid entry matched.

Function
REQ-015 SHALL implement an FSM with states IDLE, SCAN and RESP.
REQ-016 SHALL drive req_ready high only in IDLE; rsp_valid SHALL be high only in RESP.
REQ-017 SHALL, on a handshake (req_valid && req_ready), latch req_val, clear the scan pointer to 0 and enter SCAN.
REQ-018 SHALL, in SCAN, compare exactly one entry per cycle (the pointer entry) against the latched value; only valid entries match.
REQ-019 SHALL, on a match at pointer k, load rsp_idx=k and rsp_hit=1 and enter RESP; rsp_valid is therefore first high k+1 cycles after the request handshake edge.
REQ-020 SHALL, when entry DEPTH-1 does not match, load rsp_idx=0 and rsp_hit=0 and enter RESP; miss latency is DEPTH cycles.
REQ-021 SHALL make the lowest index win when several entries hold the same value.
REQ-022 SHALL hold rsp_idx and rsp_hit stable while rsp_valid && !rsp_ready.
REQ-023 SHALL return from RESP to IDLE on rsp_valid && rsp_ready; req_ready is high in the following cycle, with no combinational ready path.
REQ-024 SHALL accept writes in every state; a write takes effect at the clock edge.
REQ-025 SHALL, when a write and a compare hit the same entry in the same cycle, use the old contents for the compare.
REQ-026 SHALL NOT revisit an entry already passed by the scan when that entry is written during SCAN.
REQ-027 SHALL ignore req_val changes after acceptance, and SHALL ignore req_valid outside IDLE.

Reset
REQ-028 SHALL, on Reset, go to IDLE and clear all valid bits, the pointer, rsp_idx=0 and rsp_hit=0 (so req_ready=1 and rsp_valid=0); stored values need not be cleared.
REQ-029 SHALL abort any in-flight scan or pending response on Reset, with no response produced.
REQ-030 SHALL ignore writes while Reset is asserted.

Structure
REQ-031 SHALL place the FSM state enum and the default IDX_W/VAL_W constants in the shared package used by the PC LUT blocks.
REQ-032 SHALL implement the table (value array, valid bits, write port, one indexed read port) as sub-module pc_lut_table; the FSM, pointer and response registers live in pc_lut_encoder.

Verification
REQ-033 SHALL test this case: after reset, request 72 -> miss response (hit=0, idx=0) 32 cycles after the handshake.
REQ-034 SHALL test this case: write 5->72, 6->70, 7->71, then request 70 -> hit=1, idx=6, with rsp_valid first high 7 cycles after the handshake.
REQ-035 SHALL test this case: write 9->33 and 27->33, then request 33 -> idx=9; then write 9->0, request 33 -> idx=27.
REQ-036 SHALL test this case: during a scan for 112, write 26->112 before the pointer reaches 26 -> hit at 26; repeat with a write to 3 after the pointer has passed 3 -> miss.
REQ-037 SHALL test this case: hold rsp_ready=0 for 5 cycles -> outputs stable and req_ready=0; on release, req_ready=1 on the next cycle.
REQ-038 SHALL test this case: assert Reset at pointer 10 -> rsp_valid never rises, req_ready=1 after reset, and the previous entries now miss.
